// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: widths, opcodes
// and the fetch-stage state encoding.
package cpu_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  localparam logic [7:0] HALT_OPCODE = 8'hFF;
  localparam logic [7:0] NOP_OPCODE  = 8'h00;

  typedef enum logic [1:0] {
    ISSUE   = 2'd0,
    CAPTURE = 2'd1,
    VALID   = 2'd2,
    HALTED  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads one byte per
// ISSUE/CAPTURE/VALID round from a 1-cycle-latency memory.
//   clk, rst            : clock, async active-high reset
//   mem_grant/mem_req   : shared memory port arbitration
//   mem_address         : read address (always == pc)
//   mem_read_data       : byte returned one cycle after sample
//   instr/instr_pc      : fetched byte and its address
//   instr_valid/ready   : handshake to decode
//   redirect_valid/pc   : taken jump, overrides all but HALTED
//   halted              : HALT opcode reached
//   pc                  : current PC
module fetch_unit #(
  parameter int                   ADDR_W      = cpu_pkg::ADDR_W,
  parameter int                   DATA_W      = cpu_pkg::DATA_W,
  parameter logic [ADDR_W-1:0]    RESET_PC    = '0,
  parameter logic [DATA_W-1:0]    HALT_OPCODE = cpu_pkg::HALT_OPCODE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_grant,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);

  import cpu_pkg::*;

  fetch_state_t state;
  fetch_state_t state_nxt;

  logic redirect_take;
  logic is_halt;
  logic capture_ok;

  assign redirect_take = redirect_valid && (state != HALTED);
  assign is_halt       = (mem_read_data == HALT_OPCODE);
  // a redirect during CAPTURE throws the byte away
  assign capture_ok    = (state == CAPTURE) && !is_halt
                         && !redirect_take;
  assign mem_address   = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ISSUE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (redirect_take) begin
      state_nxt = ISSUE;
    end else begin
      unique case (state)
        ISSUE:   if (mem_grant) state_nxt = CAPTURE;
        CAPTURE: state_nxt = is_halt ? HALTED : VALID;
        VALID:   if (instr_ready) state_nxt = ISSUE;
        HALTED:  state_nxt = HALTED;
        default: state_nxt = ISSUE;
      endcase
    end
  end

  // handshake flags decode straight from state, so an
  // async reset drops them without a glitch
  always_comb begin
    mem_req     = (state == ISSUE);
    instr_valid = (state == VALID);
    halted      = (state == HALTED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      instr    <= '0;
      instr_pc <= '0;
    end else if (redirect_take) begin
      pc <= redirect_pc;
    end else if (capture_ok) begin
      pc       <= pc + ADDR_W'(1);
      instr    <= mem_read_data;
      instr_pc <= pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 1-cycle memory model
// and a queue scoreboard checked on every decode handshake.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_grant;
  logic       mem_req;
  logic [7:0] mem_address;
  logic [7:0] mem_read_data;
  logic [7:0] instr;
  logic [7:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic       halted;
  logic [7:0] pc;

  fetch_unit dut (
    .clk(clk),
    .rst(rst),
    .mem_grant(mem_grant),
    .mem_req(mem_req),
    .mem_address(mem_address),
    .mem_read_data(mem_read_data),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .halted(halted),
    .pc(pc)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic [7:0] rdata = 8'h00;
  assign mem_read_data = rdata;

  always @(posedge clk)
    if (mem_req && mem_grant) rdata <= mem[mem_address];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [15:0] exp_q [$];
  int          acc_cyc [$];

  always @(posedge clk) cyc++;

  // scoreboard monitor: one pop per accepted instruction
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_instr: got %02h@%02h, none expected",
                 instr, instr_pc);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if ({instr, instr_pc} !== e) begin
          errors++;
          $display("FAIL instr_stream: got %02h@%02h expected %02h@%02h",
                   instr, instr_pc, e[15:8], e[7:0]);
        end
      end
      acc_cyc.push_back(cyc);
    end
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input logic [7:0] a);
    exp_q.push_back({b, a});
  endtask

  task automatic wait_valid(input int n);
    for (int i = 0; i < n && !instr_valid; i++) tick();
    check("wait_valid_timeout", 32'(instr_valid), 32'd1);
  endtask

  task automatic wait_halt(input int n);
    for (int i = 0; i < n && !halted; i++) tick();
    check("wait_halt_timeout", 32'(halted), 32'd1);
  endtask

  // reset asserted 2ns after an edge, checked before the next one
  task automatic do_reset(input string tag);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check({tag, "_valid"},  32'(instr_valid), 32'd0);
    check({tag, "_halted"}, 32'(halted),      32'd0);
    check({tag, "_pc"},     32'(pc),          32'h00);
    check({tag, "_req"},    32'(mem_req),     32'd1);
    check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic bad;
    logic found;
    rst = 1'b1;
    mem_grant = 1'b1;
    instr_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h71; mem[1] = 8'h75;
    mem[2] = 8'h1A; mem[3] = 8'hFF;
    mem[8'h10] = 8'h42; mem[8'h11] = 8'hFF;
    mem[8'hFF] = 8'h12;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_req",      32'(mem_req),     32'd1);
    check("rst_pc",       32'(pc),          32'h00);
    check("rst_addr",     32'(mem_address), 32'h00);
    check("rst_valid",    32'(instr_valid), 32'd0);
    check("rst_halted",   32'(halted),      32'd0);
    check("rst_instr",    32'(instr),       32'h00);
    check("rst_instr_pc", 32'(instr_pc),    32'h00);

    // straight-line run to HALT
    acc_cyc.delete();
    push(8'h71, 8'h00); push(8'h75, 8'h01); push(8'h1A, 8'h02);
    wait_halt(40);
    check("t1_pc", 32'(pc), 32'h03);
    check("t1_req", 32'(mem_req), 32'd0);
    check("t1_count", 32'(acc_cyc.size()), 32'd3);
    if (acc_cyc.size() == 3) begin
      check("t1_gap0", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
      check("t1_gap1", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
    end
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (instr_valid || mem_req || !halted) bad = 1'b1;
    end
    check("t1_halt_absorb", 32'(bad), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    tick(); tick();
    redirect_valid = 1'b0;
    check("t1_redir_ignored_halt", 32'(halted), 32'd1);
    check("t1_redir_ignored_pc", 32'(pc), 32'h03);

    // async reset while halted, then decode stall
    do_reset("rst_in_halt");
    instr_ready = 1'b0;
    push(8'h71, 8'h00); push(8'h75, 8'h01); push(8'h1A, 8'h02);
    wait_valid(10);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (!instr_valid || instr != 8'h71 || instr_pc != 8'h00
          || pc != 8'h01 || mem_req) bad = 1'b1;
      tick();
    end
    check("t2_stall_stable", 32'(bad), 32'd0);
    instr_ready = 1'b1;
    tick();
    check("t2_reissue_req", 32'(mem_req), 32'd1);
    check("t2_reissue_addr", 32'(mem_address), 32'h01);
    check("t2_reissue_valid", 32'(instr_valid), 32'd0);
    wait_halt(40);

    // async reset mid-VALID
    do_reset("rst_pre_valid");
    instr_ready = 1'b0;
    wait_valid(10);
    do_reset("rst_in_valid");
    instr_ready = 1'b1;
    push(8'h71, 8'h00); push(8'h75, 8'h01); push(8'h1A, 8'h02);
    wait_halt(40);
    check("t6_pc", 32'(pc), 32'h03);

    // grant withheld in ISSUE
    mem_grant = 1'b0;
    do_reset("rst_grant");
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!mem_req || pc != 8'h00 || instr_valid) bad = 1'b1;
      tick();
    end
    check("t3_wait_grant", 32'(bad), 32'd0);
    mem_grant = 1'b1;
    push(8'h71, 8'h00);
    tick();
    check("t3_capture_req", 32'(mem_req), 32'd0);
    mem_grant = 1'b0;
    tick();
    check("t3_valid", 32'(instr_valid), 32'd1);
    check("t3_instr", 32'(instr), 32'h71);
    tick();
    check("t3_next_req", 32'(mem_req), 32'd1);
    check("t3_next_pc", 32'(pc), 32'h01);
    mem_grant = 1'b1;
    push(8'h75, 8'h01); push(8'h1A, 8'h02);
    wait_halt(40);

    // redirect during CAPTURE of address 1
    do_reset("rst_redir");
    push(8'h71, 8'h00); push(8'h42, 8'h10);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (!mem_req && !instr_valid && !halted && pc == 8'h01)
        found = 1'b1;
      else
        tick();
    end
    check("t4_reach_capture", 32'(found), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 8'h10;
    tick();
    redirect_valid = 1'b0;
    check("t4_pc", 32'(pc), 32'h10);
    check("t4_valid", 32'(instr_valid), 32'd0);
    check("t4_req", 32'(mem_req), 32'd1);
    wait_halt(40);
    check("t4_halt_pc", 32'(pc), 32'h11);

    // PC wrap from 0xFF
    do_reset("rst_wrap");
    redirect_valid = 1'b1; redirect_pc = 8'hFF;
    tick();
    redirect_valid = 1'b0;
    check("t5_pc_ff", 32'(pc), 32'hFF);
    push(8'h12, 8'hFF); push(8'h71, 8'h00);
    push(8'h75, 8'h01); push(8'h1A, 8'h02);
    wait_valid(10);
    tick();
    check("t5_wrap_pc", 32'(pc), 32'h00);
    check("t5_wrap_addr", 32'(mem_address), 32'h00);
    wait_halt(40);
    check("t5_halt_pc", 32'(pc), 32'h03);

    repeat (2) tick();
    check("final_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
